bitty_sequencer: RTL and testbench

- Fetch/execute sequencer for the bitty datapath core.
- Holds a program counter and fetches 16-bit instructions from an instruction memory over a req/valid handshake.
- Presents each instruction to the core with run asserted for a fixed number of cycles, then advances.
- Supports free-run, single-step, halt-on-opcode and abort.

---
 rtl/bitty_pkg.sv | 17 +
 rtl/bitty_exec_timer.sv | 41 ++++
 rtl/bitty_sequencer.sv | 148 ++++++++++++++
 tb/tb_bitty_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitty_pkg.sv
// Shared types and defaults for the bitty fetch/execute sequencer.
// State encoding plus default halt word and execute length.
package bitty_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_EXEC   = 3'd2,
        ST_NEXT   = 3'd3,
        ST_PAUSE  = 3'd4,
        ST_HALTED = 3'd5
    } state_t;

    localparam logic [15:0] HALT_INSTR_DEF  = 16'hFFFF;
    localparam int          EXEC_CYCLES_DEF = 3;

endpackage

// File: rtl/bitty_exec_timer.sv
// Execute-phase timer: loadable down-counter that holds run high
// for EXEC_CYCLES cycles and flags the last one with done.
module bitty_exec_timer
    import bitty_pkg::*;
#(
    parameter int EXEC_CYCLES = EXEC_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  logic i_clear,
    output logic o_run,
    output logic o_done
);

    localparam logic [3:0] LOAD_VAL = 4'(EXEC_CYCLES - 1);

    logic [3:0] r_cnt;
    logic       r_run;

    // Count down from EXEC_CYCLES-1; run drops after the zero cycle.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_cnt <= 4'd0;
            r_run <= 1'b0;
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
            r_run <= 1'b1;
        end else if (r_run) begin
            if (r_cnt == 4'd0) begin
                r_run <= 1'b0;
            end else begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    assign o_run  = r_run;
    assign o_done = r_run && (r_cnt == 4'd0);

endmodule

// File: rtl/bitty_sequencer.sv
// Fetch/execute sequencer for the bitty core: fetches 16-bit words
// over req/valid, runs each for EXEC_CYCLES, supports step and halt.
module bitty_sequencer
    import bitty_pkg::*;
#(
    parameter int          PC_W        = 8,
    parameter int          EXEC_CYCLES = EXEC_CYCLES_DEF,
    parameter logic [15:0] HALT_INSTR  = HALT_INSTR_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_start,
    input  logic [PC_W-1:0] i_start_pc,
    input  logic            i_step_mode,
    input  logic            i_step,
    input  logic            i_abort,
    output logic            o_mem_req,
    output logic [PC_W-1:0] o_mem_addr,
    input  logic [15:0]     i_mem_rdata,
    input  logic            i_mem_valid,
    output logic            o_core_run,
    output logic [15:0]     o_core_instr,
    output logic            o_core_reset,
    output logic [PC_W-1:0] o_pc,
    output logic            o_busy,
    output logic            o_halted,
    output logic [15:0]     o_instr_count
);

    state_t          r_state;
    state_t          w_next;
    logic [PC_W-1:0] r_pc;
    logic [15:0]     r_count;
    logic [15:0]     r_core_instr;
    logic            r_core_reset;

    logic w_start_ok;
    logic w_fetch_hit;
    logic w_is_halt;
    logic w_load;
    logic w_retire;
    logic w_run;
    logic w_done;

    // abort outranks every other event, so it gates each action here.
    assign w_start_ok  = i_start && !i_abort &&
                         (r_state == ST_IDLE || r_state == ST_HALTED);
    assign w_fetch_hit = (r_state == ST_FETCH) && i_mem_valid && !i_abort;
    assign w_is_halt   = (i_mem_rdata == HALT_INSTR);
    assign w_load      = w_fetch_hit && !w_is_halt;
    assign w_retire    = (r_state == ST_NEXT) && !i_abort;

    bitty_exec_timer #(
        .EXEC_CYCLES (EXEC_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_clear (i_abort),
        .o_run   (w_run),
        .o_done  (w_done)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state selection.
    always_comb begin
        w_next = r_state;
        if (i_abort) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_HALTED: begin
                    if (i_start) w_next = ST_FETCH;
                end
                ST_FETCH: begin
                    if (i_mem_valid) begin
                        w_next = w_is_halt ? ST_HALTED : ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (w_done) w_next = ST_NEXT;
                end
                ST_NEXT: begin
                    w_next = i_step_mode ? ST_PAUSE : ST_FETCH;
                end
                ST_PAUSE: begin
                    if (i_step) w_next = ST_FETCH;
                end
                default: w_next = ST_IDLE;
            endcase
        end
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        o_mem_req = 1'b0;
        o_busy    = 1'b0;
        o_halted  = 1'b0;
        case (r_state)
            ST_FETCH:  begin o_mem_req = 1'b1; o_busy = 1'b1; end
            ST_EXEC:   o_busy = 1'b1;
            ST_NEXT:   o_busy = 1'b1;
            ST_HALTED: o_halted = 1'b1;
            default:   o_busy = 1'b0;
        endcase
    end

    // PC, retire count, latched instruction and core reset pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc         <= '0;
            r_count      <= 16'd0;
            r_core_instr <= 16'd0;
            r_core_reset <= 1'b0;
        end else begin
            r_core_reset <= w_start_ok;
            if (w_start_ok) begin
                r_pc    <= i_start_pc;
                r_count <= 16'd0;
            end
            if (w_load) begin
                r_core_instr <= i_mem_rdata;
            end
            if (w_retire) begin
                r_pc <= r_pc + 1'b1;
                if (r_count != 16'hFFFF) begin
                    r_count <= r_count + 16'd1;
                end
            end
        end
    end

    assign o_mem_addr    = r_pc;
    assign o_pc          = r_pc;
    assign o_core_run    = w_run;
    assign o_core_instr  = r_core_instr;
    assign o_core_reset  = r_core_reset;
    assign o_instr_count = r_count;

endmodule

// File: tb/tb_bitty_sequencer.sv
// Directed bench for bitty_sequencer with a latency-programmable
// instruction memory model and fetch/run monitors.
module tb_bitty_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_start = 1'b0;
    logic [7:0]  i_start_pc = 8'h00;
    logic        i_step_mode = 1'b0;
    logic        i_step = 1'b0;
    logic        i_abort = 1'b0;
    logic        o_mem_req;
    logic [7:0]  o_mem_addr;
    logic [15:0] mem_rdata = 16'h0000;
    logic        mem_valid = 1'b0;
    logic        o_core_run;
    logic [15:0] o_core_instr;
    logic        o_core_reset;
    logic [7:0]  o_pc;
    logic        o_busy;
    logic        o_halted;
    logic [15:0] o_instr_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] mem [0:255];
    int          lat = 1;
    int          wcnt = 0;
    int          cyc = 0;
    int          run_cnt = 0;
    int          rst_cnt = 0;
    int          wait_cur = 0;
    logic        force_v = 1'b0;
    logic [15:0] force_d = 16'h0000;
    int          acc_addr [$];
    int          acc_time [$];
    int          acc_wait [$];

    bitty_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .i_start       (i_start),
        .i_start_pc    (i_start_pc),
        .i_step_mode   (i_step_mode),
        .i_step        (i_step),
        .i_abort       (i_abort),
        .o_mem_req     (o_mem_req),
        .o_mem_addr    (o_mem_addr),
        .i_mem_rdata   (mem_rdata),
        .i_mem_valid   (mem_valid),
        .o_core_run    (o_core_run),
        .o_core_instr  (o_core_instr),
        .o_core_reset  (o_core_reset),
        .o_pc          (o_pc),
        .o_busy        (o_busy),
        .o_halted      (o_halted),
        .o_instr_count (o_instr_count)
    );

    always #5 clk = ~clk;

    // Memory answers after lat request cycles; monitors log fetches.
    always @(negedge clk) begin
        cyc++;
        if (force_v) begin
            mem_valid = 1'b1;
            mem_rdata = force_d;
        end else if (o_mem_req && !mem_valid) begin
            if (wcnt == lat) begin
                mem_valid = 1'b1;
                mem_rdata = mem[o_mem_addr];
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end else begin
            mem_valid = 1'b0;
            wcnt = 0;
        end
        if (o_core_run) run_cnt++;
        if (o_core_reset) rst_cnt++;
        if (o_mem_req && !mem_valid) wait_cur++;
        if (o_mem_req && mem_valid) begin
            acc_addr.push_back(int'(o_mem_addr));
            acc_time.push_back(cyc);
            acc_wait.push_back(wait_cur);
            wait_cur = 0;
        end
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        acc_addr.delete();
        acc_time.delete();
        acc_wait.delete();
        run_cnt  = 0;
        rst_cnt  = 0;
        wait_cur = 0;
    endtask

    task automatic do_start(input logic [7:0] pc0);
        i_start_pc = pc0;
        i_start    = 1'b1;
        tick();
        i_start    = 1'b0;
    endtask

    task automatic pulse_step();
        i_step = 1'b1;
        tick();
        i_step = 1'b0;
    endtask

    task automatic wait_halt(input int maxc);
        int n = 0;
        while (!o_halted && n < maxc) begin
            tick();
            n++;
        end
        check("halt_reached", 32'(o_halted), 32'd1);
    endtask

    task automatic wait_run(input int maxc);
        int n = 0;
        while (!o_core_run && n < maxc) begin
            tick();
            n++;
        end
        check("run_seen", 32'(o_core_run), 32'd1);
    endtask

    task automatic wait_count(input logic [15:0] tgt, input int maxc);
        int n = 0;
        while (o_instr_count != tgt && n < maxc) begin
            tick();
            n++;
        end
        check("count_reached", 32'(o_instr_count), 32'(tgt));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0100 + 16'(i);
        mem[8'h10] = 16'h1111;
        mem[8'h11] = 16'h2222;
        mem[8'h12] = 16'h3333;
        mem[8'h13] = 16'hFFFF;
        mem[8'h22] = 16'hFFFF;
        mem[8'h33] = 16'hFFFF;
        mem[8'hFF] = 16'h1234;
        mem[8'h00] = 16'hFFFF;
        mem[8'h40] = 16'h4444;
        mem[8'h41] = 16'h4545;
        mem[8'h42] = 16'hFFFF;
        mem[8'h50] = 16'h5050;
        mem[8'h51] = 16'hFFFF;
        mem[8'h60] = 16'h6060;

        repeat (2) tick();
        reset = 1'b0;
        check("rst_mem_req", 32'(o_mem_req), 32'd0);
        check("rst_core_run", 32'(o_core_run), 32'd0);
        check("rst_core_instr", 32'(o_core_instr), 32'd0);
        check("rst_core_reset", 32'(o_core_reset), 32'd0);
        check("rst_pc", 32'(o_pc), 32'd0);
        check("rst_busy_halted", {o_busy, o_halted}, 32'd0);
        check("rst_count", 32'(o_instr_count), 32'd0);

        // Three instructions then halt, one-cycle memory.
        clear_mon();
        lat = 1;
        do_start(8'h10);
        check("t1_core_reset", 32'(o_core_reset), 32'd1);
        check("t1_busy", 32'(o_busy), 32'd1);
        wait_halt(100);
        check("t1_fetches", acc_addr.size(), 32'd4);
        if (acc_addr.size() == 4) begin
            check("t1_addr0", acc_addr[0], 32'h10);
            check("t1_addr1", acc_addr[1], 32'h11);
            check("t1_addr2", acc_addr[2], 32'h12);
            check("t1_addr3", acc_addr[3], 32'h13);
            check("t1_period1", acc_time[1] - acc_time[0], 32'd6);
            check("t1_period2", acc_time[2] - acc_time[1], 32'd6);
        end
        check("t1_run_cycles", run_cnt, 32'd9);
        check("t1_reset_cycles", rst_cnt, 32'd1);
        check("t1_pc", 32'(o_pc), 32'h13);
        check("t1_count", 32'(o_instr_count), 32'd3);
        check("t1_instr", 32'(o_core_instr), 32'h3333);
        check("t1_req_busy", {o_mem_req, o_busy}, 32'd0);

        // Four request cycles before each response.
        clear_mon();
        lat = 4;
        do_start(8'h20);
        wait_halt(100);
        check("t2_fetches", acc_addr.size(), 32'd3);
        if (acc_addr.size() == 3) begin
            check("t2_wait0", acc_wait[0], 32'd4);
            check("t2_wait1", acc_wait[1], 32'd4);
            check("t2_period", acc_time[1] - acc_time[0], 32'd9);
        end
        check("t2_run_cycles", run_cnt, 32'd6);
        check("t2_pc", 32'(o_pc), 32'h22);
        check("t2_count", 32'(o_instr_count), 32'd2);

        // Single-step: a step during EXEC is dropped.
        clear_mon();
        lat = 1;
        i_step_mode = 1'b1;
        do_start(8'h30);
        wait_run(20);
        pulse_step();
        wait_count(16'd1, 20);
        check("t3_paused_busy", {o_busy, o_mem_req, o_halted}, 32'd0);
        repeat (4) tick();
        check("t3_hold_count1", 32'(o_instr_count), 32'd1);
        check("t3_hold_req", 32'(o_mem_req), 32'd0);
        pulse_step();
        wait_count(16'd2, 20);
        repeat (4) tick();
        check("t3_hold_count2", 32'(o_instr_count), 32'd2);
        check("t3_hold_busy", 32'(o_busy), 32'd0);
        i_step_mode = 1'b0;
        repeat (3) tick();
        check("t3_clear_mode_req", {o_mem_req, o_busy}, 32'd0);
        check("t3_clear_mode_pc", 32'(o_pc), 32'h32);
        pulse_step();
        wait_halt(60);
        check("t3_count", 32'(o_instr_count), 32'd3);
        check("t3_pc", 32'(o_pc), 32'h33);

        // PC wraps past 8'hFF.
        clear_mon();
        do_start(8'hFF);
        wait_halt(60);
        check("t4_fetches", acc_addr.size(), 32'd2);
        if (acc_addr.size() == 2) begin
            check("t4_addr0", acc_addr[0], 32'hFF);
            check("t4_addr1", acc_addr[1], 32'h00);
        end
        check("t4_pc", 32'(o_pc), 32'h00);
        check("t4_count", 32'(o_instr_count), 32'd1);

        // Abort in the second EXEC cycle of the second instruction.
        clear_mon();
        do_start(8'h40);
        wait_count(16'd1, 30);
        wait_run(20);
        tick();
        check("t5_run_before", 32'(o_core_run), 32'd1);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        check("t5_run_dropped", 32'(o_core_run), 32'd0);
        check("t5_idle", {o_busy, o_halted, o_mem_req}, 32'd0);
        check("t5_count_held", 32'(o_instr_count), 32'd1);
        check("t5_pc_held", 32'(o_pc), 32'h41);
        force_d = 16'h7777;
        force_v = 1'b1;
        tick();
        force_v = 1'b0;
        tick();
        check("t5_late_valid_instr", 32'(o_core_instr), 32'h4545);
        check("t5_late_valid_busy", {o_busy, o_mem_req}, 32'd0);
        clear_mon();
        do_start(8'h50);
        check("t5_core_reset_on", 32'(o_core_reset), 32'd1);
        check("t5_new_addr", 32'(o_mem_addr), 32'h50);
        tick();
        check("t5_core_reset_off", 32'(o_core_reset), 32'd0);
        wait_halt(60);
        check("t5_reset_cycles", rst_cnt, 32'd1);
        if (acc_addr.size() > 0) check("t5_first_fetch", acc_addr[0], 32'h50);
        check("t5_count", 32'(o_instr_count), 32'd1);
        check("t5_pc", 32'(o_pc), 32'h51);

        // Reset mid-FETCH with data valid the same cycle.
        lat = 3;
        do_start(8'h60);
        check("t6_in_fetch", 32'(o_mem_req), 32'd1);
        force_d = 16'h6060;
        force_v = 1'b1;
        reset   = 1'b1;
        tick();
        reset   = 1'b0;
        force_v = 1'b0;
        check("t6_core_instr", 32'(o_core_instr), 32'd0);
        check("t6_pc", 32'(o_pc), 32'd0);
        check("t6_count", 32'(o_instr_count), 32'd0);
        check("t6_flags", {o_mem_req, o_core_run, o_core_reset,
                           o_busy, o_halted}, 32'd0);
        repeat (3) tick();
        check("t6_stays_idle", {o_mem_req, o_core_run, o_busy}, 32'd0);
        check("t6_instr_stays", 32'(o_core_instr), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
